// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   - address map constants (reset PC, instruction-memory window, handler)
//   - AdEL exception code
//   - IF/ID field widths and the packed IF/ID register layout
//   - next-PC source encoding produced by the next-PC selector
package if_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned EXC_W    = 5;

    localparam logic [XLEN-1:0] PC_RESET   = 32'h0000_3000;
    localparam logic [XLEN-1:0] IM_BASE    = 32'h0000_3000;
    localparam int unsigned     IM_WORDS   = 2048;
    localparam logic [XLEN-1:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    // Which rule decided the next PC; the top derives the IF/ID action from it.
    typedef enum logic [2:0] {
        NPC_EXC,
        NPC_ERET,
        NPC_HOLD,
        NPC_BR,
        NPC_SEQ
    } npc_src_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc8;
        logic               valid;
        logic               exc;
        logic [EXC_W-1:0]   exccode;
    } ifid_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
//   im_addr : byte offset into instruction memory (master -> slave)
//   im_data : instruction word, combinational response to im_addr (slave -> master)
interface if_stage_if;
    import if_stage_pkg::*;

    logic [XLEN-1:0]    im_addr;
    logic [INSTR_W-1:0] im_data;

    modport master (output im_addr, input  im_data);
    modport slave  (input  im_addr, output im_data);
endinterface

// File: rtl/if_stage_npc_sel.sv
// Combinational next-PC priority selector.
//   pc_i, stall_i, br_taken_i, br_target_i, exc_req_i, eret_i, epc_i : inputs
//   npc_o : next PC value
//   src_o : rule that won (exception > eret > stall > branch > sequential)
module if_stage_npc_sel
    import if_stage_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = if_stage_pkg::HANDLER_PC
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            exc_req_i,
    input  logic            eret_i,
    input  logic [XLEN-1:0] epc_i,
    output logic [XLEN-1:0] npc_o,
    output npc_src_e        src_o
);

    always_comb begin
        npc_o = pc_i + 32'd4;
        src_o = NPC_SEQ;
        if (exc_req_i) begin
            npc_o = HANDLER_PC;
            src_o = NPC_EXC;
        end else if (eret_i) begin
            npc_o = epc_i;
            src_o = NPC_ERET;
        end else if (stall_i) begin
            // A branch under stall is dropped; ID re-issues it afterwards.
            npc_o = pc_i;
            src_o = NPC_HOLD;
        end else if (br_taken_i) begin
            npc_o = br_target_i;
            src_o = NPC_BR;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word into IF/ID. Handles branch/jump redirect (delay
// slot kept), exception entry, eret, and fetch address errors (AdEL).
//   clk, reset           : clock, synchronous active-high reset
//   stall                : hold PC and IF/ID
//   br_taken, br_target  : redirect from ID
//   exc_req              : exception entry (flush, go to handler)
//   eret, epc            : return from exception (flush, go to epc)
//   imem                 : instruction-memory bus (master side)
//   pc                   : current fetch PC
//   ifid_*               : IF/ID pipeline register outputs
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = if_stage_pkg::PC_RESET,
    parameter logic [31:0] IM_BASE    = if_stage_pkg::IM_BASE,
    parameter int unsigned IM_WORDS   = if_stage_pkg::IM_WORDS,
    parameter logic [31:0] HANDLER_PC = if_stage_pkg::HANDLER_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [31:0]      epc,
    if_stage_if.master       imem,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_pc8,
    output logic             ifid_valid,
    output logic             ifid_exc,
    output logic [4:0]       ifid_exccode
);

    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    ifid_t       fetch;
    logic [31:0] npc;
    npc_src_e    npc_src;
    logic        fetch_err;

    if_stage_npc_sel #(
        .HANDLER_PC (HANDLER_PC)
    ) u_npc_sel (
        .pc_i        (pc_q),
        .stall_i     (stall),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .exc_req_i   (exc_req),
        .eret_i      (eret),
        .epc_i       (epc),
        .npc_o       (npc),
        .src_o       (npc_src)
    );

    assign imem.im_addr = pc_q - IM_BASE;

    assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);

    // Faulting fetches enter IF/ID as a valid nop tagged with AdEL.
    always_comb begin
        fetch.pc      = pc_q;
        fetch.pc8     = pc_q + 32'd8;
        fetch.valid   = 1'b1;
        fetch.exc     = fetch_err;
        fetch.instr   = fetch_err ? '0 : imem.im_data;
        fetch.exccode = fetch_err ? EXC_ADEL : '0;
    end

    always_comb begin
        pc_d = npc;
        case (npc_src)
            NPC_EXC, NPC_ERET: ifid_d = '0;
            NPC_HOLD:          ifid_d = ifid_q;
            default:           ifid_d = fetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= PC_RESET;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign pc           = pc_q;
    assign ifid_instr   = ifid_q.instr;
    assign ifid_pc      = ifid_q.pc;
    assign ifid_pc8     = ifid_q.pc8;
    assign ifid_valid   = ifid_q.valid;
    assign ifid_exc     = ifid_q.exc;
    assign ifid_exccode = ifid_q.exccode;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    logic        clk;
    logic        reset, stall, br_taken, exc_req, eret;
    logic [31:0] br_target, epc;
    logic [31:0] pc, ifid_instr, ifid_pc, ifid_pc8;
    logic        ifid_valid, ifid_exc;
    logic [4:0]  ifid_exccode;

    logic [31:0] mem [0:2047];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    if_stage_if imem();

    assign imem.im_data = mem[imem.im_addr[12:2]];

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .exc_req      (exc_req),
        .eret         (eret),
        .epc          (epc),
        .imem         (imem),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc8     (ifid_pc8),
        .ifid_valid   (ifid_valid),
        .ifid_exc     (ifid_exc),
        .ifid_exccode (ifid_exccode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural reference: architectural PC plus one IF/ID slot.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc8;
    logic        m_valid, m_exc;
    logic [4:0]  m_code;
    bit          model_live = 0;

    always @(posedge clk) begin
        logic bad;
        if (reset || exc_req || eret) begin
            m_pc = reset ? 32'h3000 : (exc_req ? 32'h4180 : epc);
            {m_instr, m_ipc, m_ipc8, m_valid, m_exc, m_code} = '0;
        end else if (!stall) begin
            bad      = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h4FFC);
            m_ipc    = m_pc;
            m_ipc8   = m_pc + 32'd8;
            m_valid  = 1'b1;
            m_exc    = bad;
            m_code   = bad ? 5'd4 : 5'd0;
            m_instr  = bad ? 32'd0 : mem[(m_pc - 32'h3000) / 4];
            m_pc     = br_taken ? br_target : m_pc + 32'd4;
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("cmp_pc",      pc,                m_pc);
            chk("cmp_im_addr", imem.im_addr,      m_pc - 32'h3000);
            chk("cmp_instr",   ifid_instr,        m_instr);
            chk("cmp_ifid_pc", ifid_pc,           m_ipc);
            chk("cmp_pc8",     ifid_pc8,          m_ipc8);
            chk("cmp_valid",   32'(ifid_valid),   32'(m_valid));
            chk("cmp_exc",     32'(ifid_exc),     32'(m_exc));
            chk("cmp_code",    32'(ifid_exccode), 32'(m_code));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic branch_to(input logic [31:0] t);
        br_taken = 1; br_target = t;
        tick();
        br_taken = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return 32'h3000 + 32'(4 * $urandom_range(0, 2047)) + 32'($urandom_range(1, 3));
            2:       return 32'h4FF8 + 32'(4 * $urandom_range(0, 3));
            default: return 32'h3000 + 32'(4 * $urandom_range(0, 2047));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        reset = 1; stall = 0; br_taken = 0; exc_req = 0; eret = 0;
        br_target = 0; epc = 0;

        // Reset and sequential run
        tick(); tick();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_im_addr", imem.im_addr, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_code", 32'(ifid_exccode), 32'h0);
        reset = 0;
        tick();
        chk("run_pc1", pc, 32'h3004);
        chk("model_pc1", m_pc, 32'h3004);
        chk("run_im_addr1", imem.im_addr, 32'h4);
        chk("run_ifid_pc", ifid_pc, 32'h3000);
        chk("run_pc8", ifid_pc8, 32'h3008);
        chk("run_instr", ifid_instr, mem[0]);
        chk("run_valid", 32'(ifid_valid), 32'h1);
        tick();
        chk("run_pc2", pc, 32'h3008);
        chk("run_im_addr2", imem.im_addr, 32'h8);

        // Branch with delay slot
        tick(); tick();
        chk("pre_br_pc", pc, 32'h3010);
        branch_to(32'h3100);
        chk("br_pc", pc, 32'h3100);
        chk("br_slot_pc", ifid_pc, 32'h3010);
        chk("br_slot_valid", 32'(ifid_valid), 32'h1);

        // Stall, then stall with a coincident branch
        branch_to(32'h3020);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h3020);
            chk("stall_ifid_pc", ifid_pc, 32'h3100);
            chk("stall_instr", ifid_instr, mem[32'h40]);
        end
        stall = 0;
        tick();
        chk("unstall_pc", pc, 32'h3024);
        chk("unstall_ifid_pc", ifid_pc, 32'h3020);
        stall = 1; br_taken = 1; br_target = 32'h3300;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_br_pc", pc, 32'h3024);
        end
        stall = 0; br_taken = 0;
        tick();
        chk("stall_br_resume", pc, 32'h3028);

        // Exception entry and eret
        branch_to(32'h3040);
        exc_req = 1;
        tick();
        exc_req = 0;
        chk("exc_pc", pc, 32'h4180);
        chk("exc_im_addr", imem.im_addr, 32'h1180);
        chk("exc_valid", 32'(ifid_valid), 32'h0);
        chk("exc_ifid_pc", ifid_pc, 32'h0);
        tick();
        chk("handler_ifid_pc", ifid_pc, 32'h4180);
        chk("handler_instr", ifid_instr, mem[1120]);
        eret = 1; epc = 32'h3044;
        tick();
        eret = 0;
        chk("eret_pc", pc, 32'h3044);
        chk("eret_valid", 32'(ifid_valid), 32'h0);
        exc_req = 1; eret = 1; stall = 1; br_taken = 1; br_target = 32'h3500;
        tick();
        exc_req = 0; eret = 0; stall = 0; br_taken = 0;
        chk("exc_eret_pc", pc, 32'h4180);
        chk("model_exc_eret", m_pc, 32'h4180);

        // AdEL boundaries
        branch_to(32'h3002);
        tick();
        chk("adel_unal_instr", ifid_instr, 32'h0);
        chk("adel_unal_exc", 32'(ifid_exc), 32'h1);
        chk("adel_unal_code", 32'(ifid_exccode), 32'h4);
        chk("adel_unal_valid", 32'(ifid_valid), 32'h1);
        branch_to(32'h5000);
        tick();
        chk("adel_high_exc", 32'(ifid_exc), 32'h1);
        chk("adel_high_code", 32'(ifid_exccode), 32'h4);
        branch_to(32'h4FFC);
        tick();
        chk("last_ok_exc", 32'(ifid_exc), 32'h0);
        chk("last_ok_instr", ifid_instr, mem[2047]);
        branch_to(32'h2FFC);
        tick();
        chk("adel_low_exc", 32'(ifid_exc), 32'h1);

        // Wrap-around at top of address space
        branch_to(32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc8", ifid_pc8, 32'h4);
        chk("wrap_exc", 32'(ifid_exc), 32'h1);
        tick();
        chk("wrap0_exc", 32'(ifid_exc), 32'h1);
        chk("wrap0_ifid_pc", ifid_pc, 32'h0);

        // Reset mid-run discards pending redirect
        reset = 1; br_taken = 1; br_target = 32'h3200;
        tick();
        reset = 0; br_taken = 0;
        chk("midrst_pc", pc, 32'h3000);
        chk("midrst_instr", ifid_instr, 32'h0);
        chk("midrst_ifid_pc", ifid_pc, 32'h0);
        chk("midrst_pc8", ifid_pc8, 32'h0);
        chk("midrst_valid", 32'(ifid_valid), 32'h0);

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            exc_req   = ($urandom_range(0, 39) == 0);
            eret      = ($urandom_range(0, 29) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            br_taken  = ($urandom_range(0, 4) == 0);
            br_target = rnd_addr();
            epc       = rnd_addr();
            tick();
        end
        reset = 0; exc_req = 0; eret = 0; stall = 0; br_taken = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
